z3_intack_master: RTL and testbench



---
 rtl/z3_pkg.sv | 39 +++
 rtl/z3_cycle_timer.sv | 41 ++++
 rtl/z3_intack_master.sv | 188 ++++++++++++++++++
 tb/tb_z3_intack_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z3_pkg.sv
// Shared definitions for the Zorro III quick-interrupt acknowledge master.
// Contents: FSM state enum, autovector constant, quick-interrupt address
// constant, and small elaboration-time helpers for sizing the cycle timer.
package z3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_POLL    = 3'd2,
    ST_DATA    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RECOVER = 3'd5
  } z3_state_e;

  // Autovector used when no card supplies a vector (INT2 autovector).
  localparam logic [7:0] DEFAULT_VECTOR = 8'd26;

  // Base of the quick-interrupt address space driven during the address phase.
  localparam logic [31:0] QUICKINT_ADDR = 32'hFF00_0000;

  // Address decode of the quick-interrupt space.
  function automatic logic is_quickint_addr(input logic [31:0] addr);
    return (addr == QUICKINT_ADDR);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width able to hold (win - 1), never less than one bit.
  function automatic int unsigned win_width(input int unsigned win);
    return (win <= 1) ? 1 : $clog2(win);
  endfunction

endpackage

// File: rtl/z3_cycle_timer.sv
// Loadable saturating down-counter used for the poll, DTACK and recovery
// windows.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - value loaded; the window then lasts load_val+1 cycles
//   expired_c   - combinational: count has reached zero
module z3_cycle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: load, else decrement and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/z3_intack_master.sv
// Zorro III quick-interrupt acknowledge initiator. On a pending INT2 it runs
// one quick-interrupt cycle (address, poll for SLAVE_n, data until DTACK) and
// returns the card's vector, or the autovector on no claim / DTACK timeout.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   int_req            - level interrupt request (high = pending)
//   ack_enable         - permits starting a cycle (checked only in IDLE)
//   FCS_n, quickint_cycle, DOE, DS0_n, READ - registered bus strobes
//   SLAVE_n, DTACK, din - card claim, data acknowledge, vector byte
//   vector             - last acquired vector
//   vector_valid       - one-cycle pulse when vector updates
//   autovec, bus_error - pulses coincident with vector_valid
//   busy               - high in every state except IDLE
module z3_intack_master
  import z3_pkg::*;
#(
  parameter logic [7:0]  DEFAULTVECTOR   = DEFAULT_VECTOR,
  parameter int unsigned POLL_CYCLES     = 4,
  parameter int unsigned DTACK_TIMEOUT   = 16,
  parameter int unsigned RECOVERY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       ack_enable,
  output logic       FCS_n,
  output logic       quickint_cycle,
  output logic       DOE,
  output logic       DS0_n,
  output logic       READ,
  input  logic       SLAVE_n,
  input  logic       DTACK,
  input  logic [7:0] din,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       autovec,
  output logic       bus_error,
  output logic       busy
);

  localparam int unsigned TIMER_W =
    win_width(max3(POLL_CYCLES, DTACK_TIMEOUT, RECOVERY_CYCLES));

  // A window of N cycles is loaded as N-1 and ends on the expiry cycle.
  localparam logic [TIMER_W-1:0] POLL_LOAD    = TIMER_W'(POLL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DTACK_LOAD   = TIMER_W'(DTACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RECOVER_LOAD = TIMER_W'(RECOVERY_CYCLES - 1);

  z3_state_e state_d, state_q;

  logic       fcs_n_d, fcs_n_q;
  logic       qic_d, qic_q;
  logic       doe_d, doe_q;
  logic       ds0_n_d, ds0_n_q;
  logic       read_d, read_q;
  logic [7:0] vector_d, vector_q;
  logic       vector_valid_d, vector_valid_q;
  logic       autovec_d, autovec_q;
  logic       bus_error_d, bus_error_q;
  logic       busy_d, busy_q;

  logic               timer_load_c;
  logic [TIMER_W-1:0] timer_val_c;
  logic               timer_expired_c;
  logic               in_cycle_c;
  logic [31:0]        bus_addr_c;

  z3_cycle_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load_c),
    .load_val  (timer_val_c),
    .expired_c (timer_expired_c)
  );

  // Next state, vector capture, and strobes decoded from the next state so
  // every output flop lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    autovec_d    = 1'b0;
    bus_error_d  = 1'b0;
    timer_load_c = 1'b0;
    timer_val_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (int_req && ack_enable) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d      = ST_POLL;
        timer_load_c = 1'b1;
        timer_val_c  = POLL_LOAD;
      end
      ST_POLL: begin
        // A claim on the last poll cycle still wins over the autovector.
        if (!SLAVE_n) begin
          state_d      = ST_DATA;
          timer_load_c = 1'b1;
          timer_val_c  = DTACK_LOAD;
        end else if (timer_expired_c) begin
          state_d   = ST_DONE;
          vector_d  = DEFAULTVECTOR;
          autovec_d = 1'b1;
        end
      end
      ST_DATA: begin
        // DTACK is tested first so it wins a tie with the timeout.
        if (DTACK) begin
          state_d  = ST_DONE;
          vector_d = din;
        end else if (timer_expired_c) begin
          state_d     = ST_DONE;
          vector_d    = DEFAULTVECTOR;
          bus_error_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d      = ST_RECOVER;
        timer_load_c = 1'b1;
        timer_val_c  = RECOVER_LOAD;
      end
      ST_RECOVER: begin
        if (timer_expired_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_cycle_c     = (state_d == ST_ADDR) || (state_d == ST_POLL) ||
                     (state_d == ST_DATA);
    bus_addr_c     = in_cycle_c ? QUICKINT_ADDR : 32'h0;
    fcs_n_d        = !in_cycle_c;
    qic_d          = in_cycle_c && is_quickint_addr(bus_addr_c);
    read_d         = in_cycle_c;
    doe_d          = (state_d == ST_DATA);
    ds0_n_d        = (state_d != ST_DATA);
    vector_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      fcs_n_q        <= 1'b1;
      qic_q          <= 1'b0;
      doe_q          <= 1'b0;
      ds0_n_q        <= 1'b1;
      read_q         <= 1'b0;
      vector_q       <= DEFAULTVECTOR;
      vector_valid_q <= 1'b0;
      autovec_q      <= 1'b0;
      bus_error_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcs_n_q        <= fcs_n_d;
      qic_q          <= qic_d;
      doe_q          <= doe_d;
      ds0_n_q        <= ds0_n_d;
      read_q         <= read_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      autovec_q      <= autovec_d;
      bus_error_q    <= bus_error_d;
      busy_q         <= busy_d;
    end
  end

  assign FCS_n          = fcs_n_q;
  assign quickint_cycle = qic_q;
  assign DOE            = doe_q;
  assign DS0_n          = ds0_n_q;
  assign READ           = read_q;
  assign vector         = vector_q;
  assign vector_valid   = vector_valid_q;
  assign autovec        = autovec_q;
  assign bus_error      = bus_error_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_z3_intack_master.sv
// Bench for z3_intack_master: a behavioural card answers each bus cycle from a
// planned (claim delay, DTACK delay, byte) triple; the expected outcome of the
// plan is queued and compared when the master pulses vector_valid.
module tb_z3_intack_master;

  localparam int unsigned POLL_CYCLES     = 4;
  localparam int unsigned DTACK_TIMEOUT   = 16;
  localparam int unsigned RECOVERY_CYCLES = 2;
  localparam logic [7:0]  AUTOVECTOR      = 8'd26;

  typedef struct {
    int         cd;    // poll cycles the card lets pass before claiming
    int         dd;    // data cycles the card lets pass before DTACK
    logic [7:0] data;
  } plan_t;

  typedef struct {
    logic [7:0] vec;
    logic       av;
    logic       be;
    int         poll_cyc;
    int         data_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, int_req, ack_enable, SLAVE_n, DTACK;
  logic [7:0] din;
  logic       FCS_n, quickint_cycle, DOE, DS0_n, READ;
  logic [7:0] vector;
  logic       vector_valid, autovec, bus_error, busy;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  z3_intack_master #(
    .DEFAULTVECTOR   (AUTOVECTOR),
    .POLL_CYCLES     (POLL_CYCLES),
    .DTACK_TIMEOUT   (DTACK_TIMEOUT),
    .RECOVERY_CYCLES (RECOVERY_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .int_req        (int_req),
    .ack_enable     (ack_enable),
    .FCS_n          (FCS_n),
    .quickint_cycle (quickint_cycle),
    .DOE            (DOE),
    .DS0_n          (DS0_n),
    .READ           (READ),
    .SLAVE_n        (SLAVE_n),
    .DTACK          (DTACK),
    .din            (din),
    .vector         (vector),
    .vector_valid   (vector_valid),
    .autovec        (autovec),
    .bus_error      (bus_error),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of a plan, straight from the protocol rules.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    bit claimed, acked;
    claimed    = (p.cd < int'(POLL_CYCLES));
    acked      = claimed && (p.dd < int'(DTACK_TIMEOUT));
    e.poll_cyc = claimed ? p.cd + 1 : int'(POLL_CYCLES);
    e.data_cyc = !claimed ? 0 : (acked ? p.dd + 1 : int'(DTACK_TIMEOUT));
    e.vec      = acked ? p.data : AUTOVECTOR;
    e.av       = !claimed;
    e.be       = claimed && !acked;
    return e;
  endfunction

  task automatic issue(input int cd, input int dd, input logic [7:0] data);
    plan_t p;
    p.cd = cd; p.dd = dd; p.data = data;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
  endtask

  task automatic wait_vv(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vector_valid && lat < 200);
    if (!vector_valid) check("vector_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 50);
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Behavioural card: driven on falling edges, seen by the master on the next rise.
  initial begin
    plan_t cur;
    int    n, m;
    bit    active;
    SLAVE_n = 1'b1; DTACK = 1'b0; din = 8'h00;
    active = 1'b0; n = 0; m = 0;
    cur.cd = 99; cur.dd = 99; cur.data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst || FCS_n) begin
        SLAVE_n = 1'b1;
        DTACK   = 1'b0;
        active  = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          n = 0;
          m = 0;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.cd = 99; cur.dd = 99; cur.data = 8'h00; end
        end else begin
          n++;
        end
        // n==0 is the address cycle; poll cycle k is n==k+1.
        SLAVE_n = !(n >= cur.cd + 1);
        if (!DS0_n) begin
          DTACK = (m >= cur.dd);
          din   = cur.data;
          m++;
        end else begin
          DTACK = 1'b0;
        end
      end
    end
  end

  // Monitor: counts bus-phase cycles and scores each vector_valid pulse.
  initial begin
    int   ap, dc;
    exp_t e;
    ap = 0; dc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ap = 0; dc = 0;
      end else if (vector_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vector_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("vector", 32'(vector), 32'(e.vec));
          check("autovec", 32'(autovec), 32'(e.av));
          check("bus_error", 32'(bus_error), 32'(e.be));
          check("poll_cycles", 32'(ap - 1), 32'(e.poll_cyc));
          check("data_cycles", 32'(dc), 32'(e.data_cyc));
          check("done_strobes", {27'd0, FCS_n, DOE, DS0_n, READ, quickint_cycle},
                32'b1_0_1_0_0);
          check("done_busy", 32'(busy), 32'd1);
        end
        ap = 0; dc = 0;
      end else begin
        check("flags_outside_valid", {30'd0, autovec, bus_error}, 32'd0);
        if (!FCS_n) begin
          check("cycle_strobes", {30'd0, READ, quickint_cycle}, 32'b11);
          if (DOE) dc++;
          else ap++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int lat, gap, cd, dd, k;
    bit keep;
    rst = 1'b1; int_req = 1'b0; ack_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_strobes", {27'd0, FCS_n, DOE, DS0_n, READ, quickint_cycle}, 32'b1_0_1_0_0);
    check("rst_vector", 32'(vector), 32'(AUTOVECTOR));
    check("rst_pulses", {29'd0, vector_valid, autovec, bus_error}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Best case: request seen in IDLE, vector_valid in DONE four cycles later.
    issue(0, 0, 8'h5A); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    check("best_latency", 32'(lat), 32'd4);
    wait_idle();

    // Claim on 2nd poll cycle, DTACK on 2nd data cycle.
    issue(1, 1, 8'h40); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    check("normal_latency", 32'(lat), 32'd6);
    wait_idle();

    // No claim: four poll cycles then autovector.
    issue(4, 0, 8'h11); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    check("noclaim_latency", 32'(lat), 32'd6);
    wait_idle();

    // Claim but no DTACK: sixteen data cycles then bus error.
    issue(0, 40, 8'h22); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    check("timeout_latency", 32'(lat), 32'd19);
    wait_idle();

    // Claim on the last poll cycle; DTACK on the last data cycle, then one late.
    issue(3, 15, 8'h77); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    wait_idle();
    issue(3, 16, 8'h78); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    wait_idle();

    // Back-to-back: FCS_n stays high through the recovery window and one IDLE cycle.
    issue(0, 0, 8'h41); issue(0, 0, 8'h42);
    int_req = 1'b1;
    wait_vv(lat);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (FCS_n && gap < 50);
    check("b2b_fcs_high_cycles", 32'(gap - 1), 32'(RECOVERY_CYCLES + 1));
    wait_vv(lat);
    int_req = 1'b0;
    wait_idle();

    // Gating: nothing starts while ack_enable is low.
    ack_enable = 1'b0;
    issue(0, 0, 8'h33);
    int_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("gated_idle", {30'd0, FCS_n, busy}, 32'b10);
    end
    ack_enable = 1'b1;
    @(negedge clk);
    check("gate_release_fcs", 32'(FCS_n), 32'd0);
    wait_vv(lat);
    int_req = 1'b0;
    wait_idle();

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      cd   = int'($urandom_range(0, 5));
      dd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18))
                                          : int'($urandom_range(0, 3));
      keep = 1'($urandom_range(0, 1));
      issue(cd, dd, 8'($urandom));
      if (!int_req) begin
        if ($urandom_range(0, 1) == 1) begin
          ack_enable = 1'b0;
          k = int'($urandom_range(1, 3));
          repeat (k) @(negedge clk);
          ack_enable = 1'b1;
        end
        int_req = 1'b1;
      end
      wait_vv(lat);
      if (!keep) begin
        int_req = 1'b0;
        wait_idle();
      end
    end
    int_req = 1'b0;
    wait_idle();

    // Reset in the data phase: bus goes idle, no pulse, vector back to autovector.
    issue(0, 0, 8'h3C); int_req = 1'b1; wait_vv(lat); int_req = 1'b0;
    wait_idle();
    begin
      plan_t p;
      p.cd = 0; p.dd = 40; p.data = 8'hEE;
      plan_q.push_back(p);
    end
    int_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!DOE && k < 20);
    check("reached_data_phase", 32'(DOE), 32'd1);
    rst = 1'b1;
    int_req = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {27'd0, FCS_n, DOE, DS0_n, READ, quickint_cycle}, 32'b1_0_1_0_0);
    check("midrst_busy_valid", {30'd0, busy, vector_valid}, 32'd0);
    check("midrst_vector", 32'(vector), 32'(AUTOVECTOR));
    rst = 1'b0;

    repeat (5) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("plan_queue_drained", 32'(plan_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
